mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Sequences all accesses to the byte-wide main RAM and shares it between two requesters: instruction fetch (IF) and data load/store (D).
- Converts each word, halfword or byte request into big-endian byte transfers, one transfer at a time.
- Returns the assembled result with a one-cycle done pulse (MOC-style) and rejects misaligned requests.
- Sits between the control unit and datapath (MAR/MDR side) and the RAM.

Parameters:
- ADDR_W, 9, byte address width of the RAM.

Ports:
- Clk, input, 1, system clock; rising-edge active.
- Clr, input, 1, reset; asynchronous, active-low.
- if_req, input, 1, fetch request; held until if_done.
- if_addr, input, ADDR_W, fetch byte address; always a word access.
- if_done, output, 1, one-cycle completion pulse for fetch.
- if_err, output, 1, valid with if_done; misaligned fetch.
- if_data, output, 32, fetched instruction word.
- d_req, input, 1, data request; held until d_done.
- d_rw, input, 1, 1 = read, 0 = write.
- d_type, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- d_addr, input, ADDR_W, data byte address.
- d_wdata, input, 32, store data, right-justified.
- d_done, output, 1, one-cycle completion pulse for data.
- d_err, output, 1, valid with d_done; misaligned or illegal type.
- d_rdata, output, 32, load data, zero-extended and right-justified.
- ram_en, output, 1, RAM byte-operation strobe.
- ram_rw, output, 1, 1 = read, 0 = write.
- ram_addr, output, ADDR_W, RAM byte address.
- ram_wdata, output, 8, RAM write byte.
- ram_rdata, input, 8, RAM read byte; valid the cycle after a read strobe.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (Clr = 0, immediate, asynchronous):
  - state = IDLE; last_grant = IF.
  - All outputs 0, including if_data, d_rdata and ram_en. No partial write continues.
- States: IDLE, ISSUE, CAPTURE, DONE.
- Arbitration in IDLE, on cycle c0 (the cycle a request is sampled):
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant. After reset, D wins first.
  - last_grant updates when the grant is made. The granted request's address, type, rw and wdata are latched at grant.
  - Requests arriving during busy wait; they are never dropped.
- Size: nbytes = 4 for IF and D word, 2 for halfword, 1 for byte. A 2-bit byte counter k runs from 0 to nbytes-1.
- Alignment check at grant:
  - Halfword needs addr[0] = 0. Word (IF or D) needs addr[1:0] = 00. d_type 11 is always illegal.
  - On violation: go directly to DONE at c1 with err = 1. No ram_en is ever asserted. The data output is left unchanged.
- ISSUE (byte k):
  - ram_en = 1, ram_addr = base + k, ram_rw = request rw (always read for IF).
  - Write: ram_wdata = byte (nbytes-1-k) of wdata, so the MSB goes to the lowest address.
  - Next state: reads go to CAPTURE. Writes go to ISSUE(k+1), or DONE after the last byte.
- CAPTURE:
  - Shift register = {sr[23:0], ram_rdata}; ram_en = 0.
  - Next state: ISSUE(k+1), or DONE after the last byte.
- DONE (exactly one cycle):
  - Pulse the granted requester's done; err as determined.
  - Reads copy the shift register to if_data or d_rdata. Upper bytes are zero for byte and halfword.
  - Then go to IDLE. The requester drops req during the DONE cycle; IDLE re-arbitrates the cycle after DONE.
- Latencies, with done asserted in cycle cN:
  - Word read: c9. Halfword read: c5. Byte read: c3.
  - Word write: c5. Halfword write: c3. Byte write: c2.
  - Misaligned: c1.
- Outputs:
  - Output data registers hold their value until the next successful read for the same requester.
  - err is 0 whenever done is 0.
- Address arithmetic: base + k never exceeds 2^ADDR_W - 1 for aligned accesses. No wrap logic is needed.
- ram_en is never high in two consecutive cycles during reads; writes are back-to-back.

Test Plan:
- Reset: hold Clr = 0, drive random inputs -> all outputs 0 and busy = 0. Release Clr, keep requests low -> state stays IDLE and ram_en = 0.
- Fetch word: preload RAM[4..7] = 81,00,20,05; if_req = 1, if_addr = 4 -> ram_en in c1, c3, c5, c7 with addresses 4..7; if_done in c9 with if_data = 32'h81002005 and if_err = 0.
- Store then load: D word write 32'hDEADBEEF at addr 8 -> d_done in c5 and RAM[8..11] = DE,AD,BE,EF. Then a byte read at 9 -> d_done in c3 with d_rdata = 32'h000000AD. Then a halfword read at 10 -> d_rdata = 32'h0000BEEF.
- Arbitration: after reset, raise if_req and d_req in the same cycle -> D served first, then IF starts in the cycle after D's DONE. Repeat with both high again -> D served first this time too, since last_grant = IF after the previous IF service. Keep both asserted continuously across back-to-back services -> grants strictly alternate.
- Misalignment: D halfword at addr 3 -> d_done and d_err in c1, no ram_en. IF at addr 6 -> if_err = 1, if_data unchanged. d_type = 11 -> d_err = 1.
- Reset mid-operation: D word write at 0x20, pull Clr low after the second ISSUE -> ram_en drops immediately and RAM[0x22..0x23] are unchanged. After release, a new IF request completes normally.

Source files
------------

// File: rtl/mem_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter_if
//
// Bundles every handshake and bus signal of the memory access arbiter:
//   - fetch requester   : if_req, if_addr       -> if_done, if_err, if_data
//   - data requester    : d_req, d_rw, d_type, d_addr, d_wdata
//                                               -> d_done, d_err, d_rdata
//   - byte-wide RAM     : ram_en, ram_rw, ram_addr, ram_wdata <- ram_rdata
//   - status            : busy
//
// Modports:
//   master : the arbiter itself (masters the RAM, answers both requesters)
//   slave  : the surrounding system (requesters plus the RAM)
// -----------------------------------------------------------------------------
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 9
);
    // Instruction fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              if_err;
    logic [31:0]       if_data;

    // Data load/store side
    logic              d_req;
    logic              d_rw;
    logic [1:0]        d_type;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_done;
    logic              d_err;
    logic [31:0]       d_rdata;

    // RAM side
    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // Status
    logic              busy;

    modport master (
        input  if_req, if_addr,
        input  d_req, d_rw, d_type, d_addr, d_wdata,
        input  ram_rdata,
        output if_done, if_err, if_data,
        output d_done, d_err, d_rdata,
        output ram_en, ram_rw, ram_addr, ram_wdata,
        output busy
    );

    modport slave (
        output if_req, if_addr,
        output d_req, d_rw, d_type, d_addr, d_wdata,
        output ram_rdata,
        input  if_done, if_err, if_data,
        input  d_done, d_err, d_rdata,
        input  ram_en, ram_rw, ram_addr, ram_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Shares a byte-wide RAM between instruction fetch (IF) and data load/store
// (D). Each granted request is broken into big-endian byte transfers, one at
// a time; the assembled result comes back with a one-cycle done pulse.
// Misaligned or illegal requests complete one cycle after grant with err set
// and never touch the RAM.
//
// Ports:
//   clk  : system clock, rising edge active
//   clr  : asynchronous active-low reset
//   bus  : mem_access_arbiter_if.master (requesters, RAM, busy)
//
// Latency from the request-sampling cycle c0 to done:
//   word read c9, halfword read c5, byte read c3,
//   word write c5, halfword write c3, byte write c2, misaligned c1.
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int ADDR_W = 9
) (
    input logic                  clk,
    input logic                  clr,
    mem_access_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic              last_grant_d;   // 0 = IF was granted last, 1 = D
    logic              cur_d;          // owner of the access in flight
    logic              cur_rw;
    logic [1:0]        cur_last;       // nbytes - 1
    logic [1:0]        k;              // byte counter
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [23:0]       sr;             // bytes already captured, oldest highest

    // Grant decode, evaluated while IDLE
    logic              sel_d;
    logic              sel_rw;
    logic              sel_bad;
    logic [1:0]        sel_last;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // Per-byte helpers
    logic [1:0]        k_nxt;
    logic              last_byte;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       word_in;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        sel_d     = bus.d_req && (!bus.if_req || !last_grant_d);
        sel_rw    = 1'b1;
        sel_last  = 2'd3;
        sel_addr  = bus.if_addr;
        sel_wdata = 32'h0;
        sel_bad   = (bus.if_addr[1:0] != 2'b00);
        if (sel_d) begin
            sel_rw    = bus.d_rw;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            case (bus.d_type)
                2'b00: begin
                    sel_last = 2'd0;
                    sel_bad  = 1'b0;
                end
                2'b01: begin
                    sel_last = 2'd1;
                    sel_bad  = bus.d_addr[0];
                end
                2'b10: begin
                    sel_last = 2'd3;
                    sel_bad  = (bus.d_addr[1:0] != 2'b00);
                end
                default: begin
                    sel_last = 2'd0;
                    sel_bad  = 1'b1;
                end
            endcase
        end
    end

    // Aligned accesses never cross the top of the RAM, so no wrap handling.
    assign k_nxt     = k + 2'd1;
    assign last_byte = (k == cur_last);
    assign addr_nxt  = cur_addr + {{(ADDR_W-2){1'b0}}, k_nxt};
    assign word_in   = {sr, bus.ram_rdata};

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state         <= IDLE;
            last_grant_d  <= 1'b0;
            cur_d         <= 1'b0;
            cur_rw        <= 1'b0;
            cur_last      <= 2'd0;
            k             <= 2'd0;
            cur_addr      <= '0;
            cur_wdata     <= 32'h0;
            sr            <= 24'h0;
            bus.if_done   <= 1'b0;
            bus.if_err    <= 1'b0;
            bus.if_data   <= 32'h0;
            bus.d_done    <= 1'b0;
            bus.d_err     <= 1'b0;
            bus.d_rdata   <= 32'h0;
            bus.ram_en    <= 1'b0;
            bus.ram_rw    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= 8'h00;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        last_grant_d <= sel_d;
                        cur_d        <= sel_d;
                        cur_rw       <= sel_rw;
                        cur_last     <= sel_last;
                        cur_addr     <= sel_addr;
                        cur_wdata    <= sel_wdata;
                        k            <= 2'd0;
                        sr           <= 24'h0;   // zero-extends short reads
                        bus.busy     <= 1'b1;
                        if (sel_bad) begin
                            // Rejected at grant: straight to DONE, RAM untouched.
                            state <= DONE;
                            if (sel_d) begin
                                bus.d_done <= 1'b1;
                                bus.d_err  <= 1'b1;
                            end else begin
                                bus.if_done <= 1'b1;
                                bus.if_err  <= 1'b1;
                            end
                        end else begin
                            // First byte goes out at the base address; for a
                            // write that is the most significant byte.
                            state         <= ISSUE;
                            bus.ram_en    <= 1'b1;
                            bus.ram_rw    <= sel_rw;
                            bus.ram_addr  <= sel_addr;
                            bus.ram_wdata <= sel_rw ? 8'h00 : pick_byte(sel_wdata, sel_last);
                        end
                    end
                end

                ISSUE: begin
                    if (cur_rw) begin
                        // Read data arrives next cycle; strobe drops meanwhile.
                        state      <= CAPTURE;
                        bus.ram_en <= 1'b0;
                    end else if (last_byte) begin
                        state         <= DONE;
                        bus.ram_en    <= 1'b0;
                        bus.ram_wdata <= 8'h00;
                        if (cur_d) bus.d_done  <= 1'b1;
                        else       bus.if_done <= 1'b1;
                    end else begin
                        // Writes stream back-to-back with ram_en held high.
                        k             <= k_nxt;
                        bus.ram_addr  <= addr_nxt;
                        bus.ram_wdata <= pick_byte(cur_wdata, cur_last - k_nxt);
                    end
                end

                CAPTURE: begin
                    sr <= word_in[23:0];
                    if (last_byte) begin
                        state <= DONE;
                        if (cur_d) begin
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= word_in;
                        end else begin
                            bus.if_done <= 1'b1;
                            bus.if_data <= word_in;
                        end
                    end else begin
                        state        <= ISSUE;
                        k            <= k_nxt;
                        bus.ram_en   <= 1'b1;
                        bus.ram_addr <= addr_nxt;
                    end
                end

                DONE: begin
                    // Single-cycle pulse; re-arbitration happens in IDLE.
                    state       <= IDLE;
                    bus.if_done <= 1'b0;
                    bus.if_err  <= 1'b0;
                    bus.d_done  <= 1'b0;
                    bus.d_err   <= 1'b0;
                    bus.busy    <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
//
// Directed bench for mem_access_arbiter: a byte-wide RAM model with one-cycle
// read latency, a table of single requests with hand-computed latency, error,
// data and strobe pattern, plus sequences for arbitration and mid-operation
// reset. Inputs change and outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    mem_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model: read data valid the cycle after the strobe.
    logic [7:0] mem [0:511] = '{4: 8'h81, 5: 8'h00, 6: 8'h20, 7: 8'h05,
                                32: 8'h11, 33: 8'h22, 34: 8'h33, 35: 8'h44,
                                default: 8'h00};

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_rw) bus.ram_rdata <= mem[bus.ram_addr];
            else            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    typedef struct {
        logic              is_if;
        logic              rw;
        logic [1:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                lat;     // cycle index of done
        logic              err;
        logic [31:0]       data;    // requester's data output after done
        logic [31:0]       mask;    // bit n set = ram_en high in cycle cn
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_rw    = 1'b0;
        bus.d_type  = 2'b00;
        bus.d_addr  = '0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          strobes;
        logic        got;
        logic        err;
        logic        addr_ok;
        logic        stray;
        logic [31:0] mask;
        logic [31:0] data;
        string       tag;
        tag     = $sformatf("v%0d", idx);
        n       = 0;
        strobes = 0;
        got     = 1'b0;
        err     = 1'b0;
        addr_ok = 1'b1;
        stray   = 1'b0;
        mask    = 32'h0;
        data    = 32'h0;
        @(posedge clk); #1;
        if (v.is_if) begin
            bus.if_addr = v.addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.d_rw    = v.rw;
            bus.d_type  = v.typ;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
            bus.d_req   = 1'b1;
        end
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.ram_en) begin
                mask[c] = 1'b1;
                if (bus.ram_addr != v.addr + ADDR_W'(strobes)) addr_ok = 1'b0;
                if (bus.ram_rw != (v.is_if ? 1'b1 : v.rw))     addr_ok = 1'b0;
                strobes++;
            end
            if ((bus.if_err && !bus.if_done) || (bus.d_err && !bus.d_done)) stray = 1'b1;
            if (v.is_if ? bus.d_done : bus.if_done) stray = 1'b1;
            if (v.is_if ? bus.if_done : bus.d_done) begin
                got  = 1'b1;
                n    = c;
                err  = v.is_if ? bus.if_err : bus.d_err;
                data = v.is_if ? bus.if_data : bus.d_rdata;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout: no done within 20 cycles", tag);
        end else begin
            check({tag, "_lat"},  32'(n), 32'(v.lat));
            check({tag, "_err"},  {31'b0, err}, {31'b0, v.err});
            check({tag, "_data"}, data, v.data);
            check({tag, "_mask"}, mask, v.mask);
            check({tag, "_addr"}, {31'b0, addr_ok}, 32'h1);
            check({tag, "_stray"}, {31'b0, stray}, 32'h0);
            @(posedge clk); #1;
            check({tag, "_pulse"}, {29'b0, bus.if_done, bus.d_done, bus.busy}, 32'h0);
        end
    endtask

    // Waits for any done; who = {d_done, if_done}, 0 on timeout.
    task automatic wait_done(input int limit, output logic [1:0] who, output int n);
        who = 2'b00;
        n   = 0;
        for (int c = 1; c <= limit && who == 2'b00; c++) begin
            @(posedge clk); #1;
            if (bus.if_done || bus.d_done) begin
                who = {bus.d_done, bus.if_done};
                n   = c;
            end
        end
    endtask

    initial begin
        logic [1:0] who;
        int         n;
        logic [1:0] exp_order [4];

        //              is_if rw    typ    addr     wdata         lat err   data          mask
        vecs[0]  = '{1'b1, 1'b1, 2'b10, 9'd4,  32'h0,        9, 1'b0, 32'h81002005, 32'hAA};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 9'd8,  32'hDEADBEEF, 5, 1'b0, 32'h00000000, 32'h1E};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 9'd9,  32'h0,        3, 1'b0, 32'h000000AD, 32'h02};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 9'd10, 32'h0,        5, 1'b0, 32'h0000BEEF, 32'h0A};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 9'd12, 32'hFFFF1234, 3, 1'b0, 32'h0000BEEF, 32'h06};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 9'd14, 32'hAAAAAA77, 2, 1'b0, 32'h0000BEEF, 32'h02};
        vecs[6]  = '{1'b0, 1'b1, 2'b10, 9'd12, 32'h0,        9, 1'b0, 32'h12347700, 32'hAA};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 9'd3,  32'h0,        1, 1'b1, 32'h12347700, 32'h00};
        vecs[8]  = '{1'b1, 1'b1, 2'b10, 9'd6,  32'h0,        1, 1'b1, 32'h81002005, 32'h00};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 9'd0,  32'h0,        1, 1'b1, 32'h12347700, 32'h00};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 9'h11, 32'h55667788, 1, 1'b1, 32'h12347700, 32'h00};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 9'd7,  32'h0,        3, 1'b0, 32'h00000005, 32'h02};

        // Reset held with random inputs: every output stays zero.
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.if_req  = 1'($urandom);
            bus.if_addr = ADDR_W'($urandom);
            bus.d_req   = 1'($urandom);
            bus.d_rw    = 1'($urandom);
            bus.d_type  = 2'($urandom);
            bus.d_addr  = ADDR_W'($urandom);
            bus.d_wdata = $urandom;
            if (i > 0) begin
                check("rst_ctl", {25'b0, bus.if_done, bus.if_err, bus.d_done, bus.d_err,
                                  bus.ram_en, bus.ram_rw, bus.busy}, 32'h0);
                check("rst_data", {31'b0, |{bus.if_data, bus.d_rdata, bus.ram_addr, bus.ram_wdata}}, 32'h0);
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_quiet", {30'b0, bus.ram_en, bus.busy}, 32'h0);
        end

        // Single-request table.
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        check("mem8",   {24'b0, mem[8]},    32'hDE);
        check("mem9",   {24'b0, mem[9]},    32'hAD);
        check("mem10",  {24'b0, mem[10]},   32'hBE);
        check("mem11",  {24'b0, mem[11]},   32'hEF);
        check("mem12",  {24'b0, mem[12]},   32'h12);
        check("mem13",  {24'b0, mem[13]},   32'h34);
        check("mem14",  {24'b0, mem[14]},   32'h77);
        check("mem0x11", {24'b0, mem[17]},  32'h00);

        // Arbitration: fresh reset so last_grant = IF.
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        bus.if_addr = 9'd4;
        bus.d_rw    = 1'b1;
        bus.d_type  = 2'b00;
        bus.d_addr  = 9'd9;
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        wait_done(20, who, n);
        check("arb1_who", {30'b0, who}, 32'h2);
        check("arb1_lat", 32'(n), 32'd3);
        bus.d_req = 1'b0;
        wait_done(20, who, n);
        check("arb2_who", {30'b0, who}, 32'h1);
        check("arb2_gap", 32'(n), 32'd10);
        check("arb2_data", bus.if_data, 32'h81002005);
        bus.if_req = 1'b0;

        // Both held across back-to-back services: strict alternation, D first.
        @(posedge clk); #1;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        exp_order[0] = 2'b10;
        exp_order[1] = 2'b01;
        exp_order[2] = 2'b10;
        exp_order[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wait_done(30, who, n);
            check($sformatf("alt%0d_who", i), {30'b0, who}, {30'b0, exp_order[i]});
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a word write at 0x20.
        @(posedge clk); #1;
        bus.d_rw    = 1'b0;
        bus.d_type  = 2'b10;
        bus.d_addr  = 9'h20;
        bus.d_wdata = 32'hCAFEF00D;
        bus.d_req   = 1'b1;
        @(posedge clk); #1;     // c1: first ISSUE
        @(posedge clk); #1;     // c2: second ISSUE
        @(posedge clk); #1;     // c3: third ISSUE under way
        check("mid_en_before", {31'b0, bus.ram_en}, 32'h1);
        clr       = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("mid_en_after", {30'b0, bus.ram_en, bus.busy}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b1;
        check("mid_mem20", {24'b0, mem[32]}, 32'hCA);
        check("mid_mem21", {24'b0, mem[33]}, 32'hFE);
        check("mid_mem22", {24'b0, mem[34]}, 32'h33);
        check("mid_mem23", {24'b0, mem[35]}, 32'h44);
        run_vec(12, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
